// File: rtl/bridge_word_serializer.sv
// -----------------------------------------------------------------------------
// bridge_word_serializer
//
// Turns one 32-bit APF bridge word access into four paced byte accesses on a
// byte-wide memory port. Writes are split big-endian (bits [31:24] go to byte
// offset 0). Reads fetch four bytes, reassemble them and publish the word
// with a one-cycle ready pulse. A fixed-bits/mask address match selects the
// instance so several serializers can share one bridge.
//
// Ports
//   clk_74a          bridge clock, the only clock
//   reset_n          asynchronous active-low reset
//   bridge_addr      bridge byte address, bits [1:0] ignored
//   bridge_wr        single-cycle write strobe
//   bridge_wr_data   write word, big-endian
//   bridge_rd        single-cycle read strobe
//   bridge_rd_data   last completed read word, big-endian
//   bridge_rd_ready  one-cycle pulse when bridge_rd_data has updated
//   selected         combinational address match
//   busy             a word operation is in progress
//   mem_address      {word_addr[31:2], byte_idx}
//   mem_wr_data      byte being written
//   mem_wr           one-cycle byte write pulse
//   mem_rd           one-cycle byte read pulse
//   mem_rd_data      byte read result, sampled READ_CYCLES-1 cycles after mem_rd
// -----------------------------------------------------------------------------
module bridge_word_serializer #(
    parameter logic [31:0] FIXED_BITS   = 32'h10000000,
    parameter logic [31:0] FIXED_MASK   = 32'hffffff80,
    parameter int          READ_CYCLES  = 16,
    parameter int          WRITE_CYCLES = 2
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic        bridge_rd_ready,
    output logic        selected,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_wr_data,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rd_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // The gap counter is loaded with cycles-minus-one so that a value of zero
    // marks the last cycle of the current byte slot.
    localparam logic [7:0] WR_GAP = 8'(WRITE_CYCLES - 1);
    localparam logic [7:0] RD_GAP = 8'(READ_CYCLES - 1);

    logic [1:0]  state_q,     state_d;
    logic [7:0]  gap_q,       gap_d;
    logic [1:0]  byte_idx_q,  byte_idx_d;
    logic [29:0] word_addr_q, word_addr_d;
    logic [31:0] wr_word_q,   wr_word_d;
    logic [31:0] asm_q,       asm_d;
    logic [31:0] rd_data_q,   rd_data_d;
    logic        rd_ready_q,  rd_ready_d;
    logic        mem_wr_q,    mem_wr_d;
    logic        mem_rd_q,    mem_rd_d;

    // Big-endian lane: byte offset k lives at bit 8*(3-k); for a 2-bit index
    // 3-k is simply its bitwise inverse.
    logic [4:0] lane_lsb;
    assign lane_lsb = {~byte_idx_q, 3'b000};

    // Word alignment makes the two low address bits don't-care.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bridge_addr[1:0];

    assign selected = (bridge_addr & FIXED_MASK) == FIXED_BITS;

    always_comb begin
        // NOTE: every next-state variable gets a hold default first so no path
        // through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        gap_d       = gap_q;
        byte_idx_d  = byte_idx_q;
        word_addr_d = word_addr_q;
        wr_word_d   = wr_word_q;
        asm_d       = asm_q;
        rd_data_d   = rd_data_q;
        rd_ready_d  = 1'b0;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Write has priority; a read in the same cycle is dropped.
                if (bridge_wr && selected) begin
                    word_addr_d = bridge_addr[31:2];
                    wr_word_d   = bridge_wr_data;
                    byte_idx_d  = 2'd0;
                    gap_d       = WR_GAP;
                    mem_wr_d    = 1'b1;
                    state_d     = ST_WRITE;
                end else if (bridge_rd && selected) begin
                    word_addr_d = bridge_addr[31:2];
                    byte_idx_d  = 2'd0;
                    gap_d       = RD_GAP;
                    mem_rd_d    = 1'b1;
                    state_d     = ST_READ;
                end
            end

            ST_WRITE: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (byte_idx_q == 2'd3) begin
                    state_d = ST_IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    gap_d      = WR_GAP;
                    mem_wr_d   = 1'b1;
                end
            end

            ST_READ: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else begin
                    asm_d[lane_lsb +: 8] = mem_rd_data;
                    if (byte_idx_q == 2'd3) begin
                        // Publish the word including the byte captured now.
                        rd_data_d  = asm_d;
                        rd_ready_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        gap_d      = RD_GAP;
                        mem_rd_d   = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= 8'd0;
            byte_idx_q  <= 2'd0;
            word_addr_q <= 30'd0;
            wr_word_q   <= 32'd0;
            asm_q       <= 32'd0;
            rd_data_q   <= 32'd0;
            rd_ready_q  <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational block.
            state_q     <= state_d;
            gap_q       <= gap_d;
            byte_idx_q  <= byte_idx_d;
            word_addr_q <= word_addr_d;
            wr_word_q   <= wr_word_d;
            asm_q       <= asm_d;
            rd_data_q   <= rd_data_d;
            rd_ready_q  <= rd_ready_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
        end
    end

    assign busy            = state_q != ST_IDLE;
    assign bridge_rd_data  = rd_data_q;
    assign bridge_rd_ready = rd_ready_q;
    assign mem_wr          = mem_wr_q;
    assign mem_rd          = mem_rd_q;
    // Both are pure functions of held registers, so they stay stable between
    // pulses and keep their last value after the operation ends.
    assign mem_address     = {word_addr_q, byte_idx_q};
    assign mem_wr_data     = wr_word_q[lane_lsb +: 8];

endmodule

// File: tb/tb_bridge_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_bridge_word_serializer
//
// Two instances share one bridge stimulus stream: one with default pacing and
// one with the minimum pacing (1/1). A reference model turns every strobe
// into a timeline of expected byte pulses and ready events per instance; a
// negedge monitor compares the DUT outputs against that timeline every cycle.
// -----------------------------------------------------------------------------
module tb_bridge_word_serializer;

    localparam logic [31:0] BITS = 32'h10000000;
    localparam logic [31:0] MASK = 32'hffffff80;
    localparam int RC0 = 16, WC0 = 2, RC1 = 1, WC1 = 1;

    localparam logic [2:0] K_WR  = 3'b100;
    localparam logic [2:0] K_RD  = 3'b010;
    localparam logic [2:0] K_RDY = 3'b001;

    typedef struct {
        int          cyc;
        logic [2:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk_74a = 1'b0;
    logic        reset_n;
    logic [31:0] bridge_addr;
    logic        bridge_wr, bridge_rd;
    logic [31:0] bridge_wr_data;

    logic [31:0] rd_data0, rd_data1, mem_addr0, mem_addr1;
    logic        rd_ready0, rd_ready1, sel0, sel1, busy0, busy1;
    logic        mem_wr0, mem_wr1, mem_rd0, mem_rd1;
    logic [7:0]  wr_byte0, wr_byte1, rd_byte0, rd_byte1;

    // Byte memory model: each byte reads as its address low byte plus 0x10.
    assign rd_byte0 = mem_addr0[7:0] + 8'h10;
    assign rd_byte1 = mem_addr1[7:0] + 8'h10;

    bridge_word_serializer #(
        .FIXED_BITS(BITS), .FIXED_MASK(MASK),
        .READ_CYCLES(RC0), .WRITE_CYCLES(WC0)
    ) dut0 (
        .clk_74a(clk_74a), .reset_n(reset_n),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
        .bridge_rd_data(rd_data0), .bridge_rd_ready(rd_ready0),
        .selected(sel0), .busy(busy0), .mem_address(mem_addr0),
        .mem_wr_data(wr_byte0), .mem_wr(mem_wr0), .mem_rd(mem_rd0),
        .mem_rd_data(rd_byte0)
    );

    bridge_word_serializer #(
        .FIXED_BITS(BITS), .FIXED_MASK(MASK),
        .READ_CYCLES(RC1), .WRITE_CYCLES(WC1)
    ) dut1 (
        .clk_74a(clk_74a), .reset_n(reset_n),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
        .bridge_rd_data(rd_data1), .bridge_rd_ready(rd_ready1),
        .selected(sel1), .busy(busy1), .mem_address(mem_addr1),
        .mem_wr_data(wr_byte1), .mem_wr(mem_wr1), .mem_rd(mem_rd1),
        .mem_rd_data(rd_byte1)
    );

    always #5 clk_74a = ~clk_74a;

    int cyc = 0;
    always @(posedge clk_74a) cyc <= cyc + 1;

    ev_t         q0[$];
    ev_t         q1[$];
    int          start_at[2];
    int          free_at[2];
    logic [31:0] exp_rd[2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference model: an accepted strobe at cycle T schedules four byte
    // slots starting at T+1, spaced by the instance's pacing; a read adds a
    // ready event one full pacing interval after its last byte slot.
    task automatic model_strobe(input logic wr, input logic rd,
                                input logic [31:0] a, input logic [31:0] wd);
        ev_t         e;
        int          rc, wc;
        logic [7:0]  b;
        logic [31:0] word;
        logic        sel;
        sel = (a & MASK) == BITS;
        for (int d = 0; d < 2; d++) begin
            rc = (d == 0) ? RC0 : RC1;
            wc = (d == 0) ? WC0 : WC1;
            if (sel && (wr || rd) && cyc >= free_at[d]) begin
                start_at[d] = cyc + 1;
                if (wr) begin
                    for (int k = 0; k < 4; k++) begin
                        e.cyc  = cyc + 1 + k * wc;
                        e.kind = K_WR;
                        e.addr = {a[31:2], 2'(k)};
                        e.data = {24'd0, wd[31-8*k -: 8]};
                        push_ev(d, e);
                    end
                    free_at[d] = cyc + 1 + 4 * wc;
                end else begin
                    word = 32'd0;
                    for (int k = 0; k < 4; k++) begin
                        b      = {a[7:2], 2'(k)} + 8'h10;
                        word   = {word[23:0], b};
                        e.cyc  = cyc + 1 + k * rc;
                        e.kind = K_RD;
                        e.addr = {a[31:2], 2'(k)};
                        e.data = 32'd0;
                        push_ev(d, e);
                    end
                    e.cyc  = cyc + 1 + 4 * rc;
                    e.kind = K_RDY;
                    e.addr = 32'd0;
                    e.data = word;
                    push_ev(d, e);
                    free_at[d] = cyc + 1 + 4 * rc;
                end
            end
        end
    endtask

    task automatic mon(input int d, input logic wr, input logic rd, input logic rdy,
                       input logic bsy, input logic [31:0] ma, input logic [7:0] wb,
                       input logic [31:0] rdat);
        ev_t        e;
        bit         have;
        logic [2:0] exp_k;
        logic       exp_b;
        have  = 1'b0;
        exp_k = 3'b000;
        if (d == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front(); have = 1'b1;
        end else if (d == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front(); have = 1'b1;
        end
        if (have) exp_k = e.kind;
        if (have && e.kind == K_RDY) exp_rd[d] = e.data;
        check($sformatf("d%0d pulses{wr,rd,ready}", d), 32'({wr, rd, rdy}), 32'(exp_k));
        if (have && e.kind != K_RDY)
            check($sformatf("d%0d mem_address", d), ma, e.addr);
        if (have && e.kind == K_WR)
            check($sformatf("d%0d mem_wr_data", d), 32'(wb), e.data);
        exp_b = (cyc >= start_at[d]) && (cyc < free_at[d]);
        check($sformatf("d%0d busy", d), 32'(bsy), 32'(exp_b));
        check($sformatf("d%0d bridge_rd_data", d), rdat, exp_rd[d]);
    endtask

    always @(negedge clk_74a) begin
        mon(0, mem_wr0, mem_rd0, rd_ready0, busy0, mem_addr0, wr_byte0, rd_data0);
        mon(1, mem_wr1, mem_rd1, rd_ready1, busy1, mem_addr1, wr_byte1, rd_data1);
    end

    // All stimulus moves happen 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_74a);
            #1;
        end
    endtask

    task automatic strobe(input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] wd);
        logic exp_sel;
        bridge_addr    = a;
        bridge_wr      = wr;
        bridge_rd      = rd;
        bridge_wr_data = wd;
        #1;
        exp_sel = (a & MASK) == BITS;
        check("d0 selected", 32'(sel0), 32'(exp_sel));
        check("d1 selected", 32'(sel1), 32'(exp_sel));
        model_strobe(wr, rd, a, wd);
        step(1);
        bridge_wr = 1'b0;
        bridge_rd = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " d0 rd_data"},  rd_data0,          32'd0);
        check({tag, " d0 ready"},    32'(rd_ready0),    32'd0);
        check({tag, " d0 busy"},     32'(busy0),        32'd0);
        check({tag, " d0 mem_addr"}, mem_addr0,         32'd0);
        check({tag, " d0 wr_byte"},  32'(wr_byte0),     32'd0);
        check({tag, " d0 strobes"},  32'({mem_wr0, mem_rd0}), 32'd0);
        check({tag, " d1 rd_data"},  rd_data1,          32'd0);
        check({tag, " d1 ready"},    32'(rd_ready1),    32'd0);
        check({tag, " d1 busy"},     32'(busy1),        32'd0);
        check({tag, " d1 mem_addr"}, mem_addr1,         32'd0);
        check({tag, " d1 wr_byte"},  32'(wr_byte1),     32'd0);
        check({tag, " d1 strobes"},  32'({mem_wr1, mem_rd1}), 32'd0);
    endtask

    initial begin
        int          t0;
        int          op;
        logic [31:0] a;
        reset_n        = 1'b0;
        bridge_addr    = 32'd0;
        bridge_wr      = 1'b0;
        bridge_rd      = 1'b0;
        bridge_wr_data = 32'd0;
        for (int d = 0; d < 2; d++) begin
            start_at[d] = 0;
            free_at[d]  = 0;
            exp_rd[d]   = 32'd0;
        end
        #2;
        check_all_zero("reset");
        step(3);
        reset_n = 1'b1;
        step(2);

        // Word write at default pacing.
        strobe(1'b1, 1'b0, 32'h10000004, 32'hA1B2C3D4);
        step(12);
        // Word read; expected word 32'h10111213.
        strobe(1'b0, 1'b1, 32'h10000000, 32'd0);
        step(70);
        // Decode: just outside the window, then the last word inside it.
        strobe(1'b1, 1'b0, 32'h10000080, 32'hDEADBEEF);
        step(10);
        strobe(1'b1, 1'b0, 32'h1000007C, 32'h01234567);
        step(12);
        // Simultaneous strobes: write only.
        strobe(1'b1, 1'b1, 32'h10000040, 32'h55AA33CC);
        step(12);
        // Second write while busy is dropped.
        strobe(1'b1, 1'b0, 32'h10000010, 32'h11223344);
        step(2);
        strobe(1'b1, 1'b0, 32'h10000020, 32'h99887766);
        step(12);
        // Reset in the middle of a slow read.
        t0 = cyc;
        strobe(1'b0, 1'b1, 32'h10000030, 32'd0);
        while (cyc < t0 + 30) step(1);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            start_at[d] = 0;
            free_at[d]  = 0;
            exp_rd[d]   = 32'd0;
        end
        step(3);
        reset_n = 1'b1;
        step(2);
        strobe(1'b0, 1'b1, 32'h10000050, 32'd0);
        step(70);

        // Randomized traffic, including overlaps and out-of-window accesses.
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) a = $urandom;
            else a = BITS | 32'($urandom_range(0, 127));
            if (op == 0)      strobe(1'b1, 1'b0, a, $urandom);
            else if (op == 1) strobe(1'b0, 1'b1, a, $urandom);
            else if (op == 2) strobe(1'b1, 1'b1, a, $urandom);
            step($urandom_range(0, 70));
        end

        step(80);
        check("d0 events outstanding", 32'(q0.size()), 32'd0);
        check("d1 events outstanding", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_word_serializer.md
# bridge_word_serializer

Upstream neighbour of the high-score bridge window. Converts one 32-bit APF bridge word access in `clk_74a` into four sequential byte accesses on a paced byte port, for byte-wide memories behind slow or clock-crossed paths. Reads are reassembled into a 32-bit word and returned with a ready pulse. Address decode is a fixed-bits/mask match, so several instances can share the bridge.

## Interface
Parameters:
- `FIXED_BITS`, 32'h10000000, value that address bits under `FIXED_MASK` must equal.
- `FIXED_MASK`, 32'hffffff80, address bits compared for selection.
- `READ_CYCLES`, 16, cycles from a `mem_rd` pulse to its data capture; legal range 1–255.
- `WRITE_CYCLES`, 2, spacing in cycles between consecutive `mem_wr` pulses; legal range 1–255.

Ports:
- `clk_74a` in 1: bridge clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `bridge_addr` in 32: bridge byte address; bits [1:0] are ignored (word aligned).
- `bridge_wr` in 1: single-cycle write strobe.
- `bridge_wr_data` in 32: write word, big-endian: [31:24] goes to byte offset 0.
- `bridge_rd` in 1: single-cycle read strobe.
- `bridge_rd_data` out 32: last completed read word, big-endian.
- `bridge_rd_ready` out 1: one-cycle pulse when `bridge_rd_data` has updated.
- `selected` out 1: combinational; `(bridge_addr & FIXED_MASK) == FIXED_BITS`.
- `busy` out 1: a word operation is in progress.
- `mem_address` out 32: `{word_addr[31:2], byte_idx}`.
- `mem_wr_data` out 8: byte being written.
- `mem_wr` out 1: one-cycle byte write pulse.
- `mem_rd` out 1: one-cycle byte read pulse.
- `mem_rd_data` in 8: byte read result; sampled as defined in Timing.

## Operation
- States: IDLE, WRITE, READ.
- Reset values: state IDLE, all outputs and counters 0 (`bridge_rd_data`=0, `busy`=0, `mem_*`=0).
- IDLE:
  - `bridge_wr && selected` latches the address and data, clears `byte_idx`, and goes to WRITE.
  - Otherwise `bridge_rd && selected` latches the address and goes to READ.
  - If both strobes are high in the same cycle, the write wins and the read is dropped.
- WRITE: issues bytes 0..3, one `mem_wr` every `WRITE_CYCLES`. Returns to IDLE after the last gap.
- READ: issues bytes 0..3, one `mem_rd` every `READ_CYCLES`. Each byte is captured into the assembly register at offset `byte_idx`. After byte 3 is captured, the assembled word is copied to `bridge_rd_data`, `bridge_rd_ready` pulses, and the block returns to IDLE.
- Strobes arriving while not in IDLE are dropped. The bridge is responsible for spacing its accesses.
- Strobes for addresses where `selected`=0 are ignored in every state.
- `bridge_rd_data` holds its value between reads. A write never changes it.
- `mem_address` and `mem_wr_data` stay stable from each pulse until the next pulse or until IDLE.
- Reset asserted mid-operation: the block aborts immediately and all outputs return to reset values. No partial word is published.

## Timing
- Strobe accepted at cycle T (sampled on the edge ending T).
- Write:
  - `mem_wr` is high in cycles T+1+k·WRITE_CYCLES for k=0..3.
  - `busy` is high in cycles T+1 .. T+4·WRITE_CYCLES.
  - The next strobe can be accepted at cycle T+1+4·WRITE_CYCLES.
- Read:
  - `mem_rd` is high in cycles R_k = T+1+k·READ_CYCLES.
  - Byte k is sampled at the edge ending cycle R_k+READ_CYCLES−1.
  - `bridge_rd_data` updates and `bridge_rd_ready` pulses in cycle T+1+4·READ_CYCLES.
  - `busy` is high from T+1 until the ready cycle, and low in the ready cycle.
  - With defaults: ready at T+65.
- Counters: 8-bit gap counter, 2-bit `byte_idx`. `byte_idx` does not wrap past 3 within one operation.
- `selected` has zero latency (combinational).

## Test plan
- **Write at defaults.** Write 32'hA1B2C3D4 to 0x10000004 → `mem_wr` at T+1,3,5,7 with addresses 0x10000004..07 and data A1,B2,C3,D4; `busy` low at T+9.
- **Read at defaults.** Read 0x10000000 with a model returning byte = addr[7:0]+0x10 → four `mem_rd` 16 cycles apart; `bridge_rd_data`=32'h10111213 with `bridge_rd_ready` at T+65.
- **Decode.** Write to 0x10000080 (outside the mask) → no `mem_wr`, `selected`=0, `busy` stays 0. Write to 0x1000007C → accepted.
- **Simultaneous strobes and overlap.**
  - `bridge_wr` and `bridge_rd` in the same cycle → write only; `bridge_rd_ready` never pulses.
  - Second write during `busy` → dropped; exactly 4 `mem_wr` pulses.
- **Reset mid-read.** Deassert `reset_n` at T+30 → all outputs 0 asynchronously; no ready pulse. After release, a fresh read completes normally.
- **Minimum pacing.** `READ_CYCLES`=1, `WRITE_CYCLES`=1 → `mem_wr` on 4 consecutive cycles; read ready at T+5 with the correct word.
